lc4_muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide/modulo unit for the superscalar LC4 pipeline. It replaces the single-cycle multiplier and combinational divider path in the execute stage with a WIDTH-cycle shift-add / restoring-division engine. A valid/ready handshake and a destination tag let the pipeline stall on it or flush it. It honours the global write enable `gwe` like every other state element in the datapath.

---
 rtl/lc4_muldiv_pkg.sv | 22 ++
 rtl/lc4_div_step.sv | 28 ++
 rtl/lc4_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_lc4_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_muldiv_pkg.sv
// lc4_muldiv_pkg
//   Shared definitions for the iterative LC4 multiply/divide unit:
//   operation encodings, FSM state type and iteration-counter sizing.
package lc4_muldiv_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Counter must hold 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lc4_div_step.sv
// lc4_div_step
//   One combinational restoring-division step.
//   Ports:
//     rem_in   [WIDTH-1:0]  current partial remainder (always < divisor)
//     dvd_bit               next dividend bit, shifted in at the LSB
//     divisor  [WIDTH-1:0]  divisor
//     rem_out  [WIDTH-1:0]  next partial remainder
//     q_bit                 quotient bit produced by this step
module lc4_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  assign partial = {rem_in, dvd_bit};
  assign q_bit   = (partial >= {1'b0, divisor});
  // The true difference is below the divisor, so the low WIDTH bits are exact.
  assign diff    = partial[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff : partial[WIDTH-1:0];

endmodule

// File: rtl/lc4_muldiv_unit.sv
// lc4_muldiv_unit
//   Iterative unsigned multiply / divide / modulo for the LC4 execute stage.
//   WIDTH-cycle shift-add multiply and restoring division, valid/ready
//   handshakes, tag pass-through, flush, and global write enable.
//   Ports:
//     clk, rst_n (sync, active-low), gwe (global write enable)
//     i_valid/o_ready : request handshake (o_ready only in IDLE)
//     i_op            : 00 MUL, 01 DIV, 10 MOD, 11 reserved (result 0)
//     i_a, i_b        : operands; i_tag returned with the result
//     i_flush         : squash any operation in flight
//     o_valid/i_ready : result handshake; o_result, o_tag
//     o_busy          : unit not IDLE
module lc4_muldiv_unit
  import lc4_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gwe,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int unsigned      CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] sr_q;    // MUL: {acc, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q;  // multiplicand (MUL) or divisor (DIV/MOD)
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   res_q;
  logic [TAG_W-1:0]   tag_q;

  // Multiply step: conditionally add multiplicand into the upper half,
  // then shift right with the carry entering at the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] sr_mul;

  assign mul_sum = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, opnd_q} : '0);
  assign sr_mul  = {mul_sum, sr_q[WIDTH-1:1]};

  // Divide step: dividend MSB shifts into the remainder, quotient bit
  // shifts in at the bottom of the same register.
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic [2*WIDTH-1:0] sr_div;

  lc4_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (sr_q[2*WIDTH-1:WIDTH]),
    .dvd_bit (sr_q[WIDTH-1]),
    .divisor (opnd_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign sr_div = {rem_nxt, sr_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
      op_q   <= OP_MUL;
      res_q  <= '0;
      tag_q  <= '0;
    end else if (gwe) begin
      if (i_flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_valid) begin
              op_q  <= i_op;
              tag_q <= i_tag;
              cnt   <= '0;
              if (i_op == OP_MUL) begin
                sr_q   <= {{WIDTH{1'b0}}, i_b};
                opnd_q <= i_a;
                state  <= S_MUL;
              end else if ((i_op == OP_DIV || i_op == OP_MOD) && i_b != '0) begin
                sr_q   <= {{WIDTH{1'b0}}, i_a};
                opnd_q <= i_b;
                state  <= S_DIV;
              end else begin
                // Divide by zero and reserved op complete immediately with 0.
                res_q <= '0;
                state <= S_DONE;
              end
            end
          end
          S_MUL: begin
            sr_q <= sr_mul;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              res_q <= sr_mul[WIDTH-1:0];
              state <= S_DONE;
            end
          end
          S_DIV: begin
            sr_q <= sr_div;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              res_q <= (op_q == OP_MOD) ? sr_div[2*WIDTH-1:WIDTH] : sr_div[WIDTH-1:0];
              state <= S_DONE;
            end
          end
          S_DONE: begin
            if (i_ready) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready  = (state == S_IDLE);
  assign o_busy   = (state != S_IDLE);
  assign o_valid  = (state == S_DONE);
  assign o_result = res_q;
  assign o_tag    = tag_q;

endmodule

// File: tb/tb_lc4_muldiv_unit.sv
// tb_lc4_muldiv_unit
//   Scenario-driven bench for lc4_muldiv_unit (WIDTH=16, TAG_W=3).
//   Expected results are computed from operands with a reference model,
//   queued at issue and popped when the unit presents a result.
module tb_lc4_muldiv_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          rst_n, gwe, i_valid, i_flush, i_ready;
  logic [1:0]    i_op;
  logic [W-1:0]  i_a, i_b;
  logic [TW-1:0] i_tag;
  logic          o_ready, o_valid, o_busy;
  logic [W-1:0]  o_result;
  logic [TW-1:0] o_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lc4_muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gwe      (gwe),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_tag    (i_tag),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_tag    (o_tag),
    .o_busy   (o_busy)
  );

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return (b == 0) ? '0 : a / b;
      2'b10:   return (b == 0) ? '0 : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
    if (op == 2'b11 || (op != 2'b00 && b == 0)) return 1;
    return W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; returns in cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    exp_t e;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_issue: o_ready=%b required 1", o_ready);
    end
    e.res = model(op, a, b);
    e.tag = tag;
    sb.push_back(e);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = tag;
    tick();
    i_valid = 1'b0;
  endtask

  // Waits (bounded) for o_valid and compares against the scoreboard head.
  // start is the cycle offset from the accept cycle at entry.
  task automatic collect(input int start, output int lat);
    exp_t e;
    lat = start;
    while (o_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: o_valid=%b required 1 within 200 cycles", o_valid);
      if (sb.size() != 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_result: o_result=%h with empty scoreboard", o_result);
    end else begin
      e = sb.pop_front();
      if (o_result !== e.res) begin
        errors++;
        $display("FAIL result: o_result=%h required %h", o_result, e.res);
      end
      checks++;
      if (o_tag !== e.tag) begin
        errors++;
        $display("FAIL tag: o_tag=%h required %h", o_tag, e.tag);
      end
    end
  endtask

  task automatic check_latency(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s_latency: cycles=%0d required %0d", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: value=%b required %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gwe = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_op = '0; i_a = '0; i_b = '0; i_tag = '0;
    repeat (3) tick();
    check_bit("reset_o_ready", o_ready, 1'b1);
    check_bit("reset_o_valid", o_valid, 1'b0);
    check_bit("reset_o_busy", o_busy, 1'b0);
    checks++;
    if (o_result !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: o_result=%h o_tag=%h required 0 0", o_result, o_tag);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul_basic();
    int lat;
    issue(2'b00, 16'd7, 16'd9, 3'd5);
    check_bit("mul_busy", o_busy, 1'b1);
    check_bit("mul_ready_low", o_ready, 1'b0);
    collect(1, lat);
    check_latency("mul", lat, 17);
    tick();
    check_bit("mul_ready_after", o_ready, 1'b1);
  endtask

  task automatic test_divmod();
    logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
    logic [15:0] as  [4] = '{16'd100, 16'd100, 16'hFFFF, 16'hFFFF};
    logic [15:0] bs  [4] = '{16'd7, 16'd7, 16'd1, 16'hFFFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], TW'(i + 1));
      collect(1, lat);
      check_latency("divmod", lat, 17);
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [1:0] ops [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 16'h1234, (i == 2) ? 16'd3 : 16'd0, TW'(6 - i));
      collect(1, lat);
      check_latency("zero_div", lat, 1);
      tick();
      check_bit("zero_div_ready_t2", o_ready, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] held;
    i_ready = 1'b0;
    issue(2'b10, 16'd1000, 16'd33, 3'd7);
    collect(1, lat);
    check_latency("bp", lat, 17);
    held = o_result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bit("bp_valid_held", o_valid, 1'b1);
      check_bit("bp_ready_low", o_ready, 1'b0);
      checks++;
      if (o_result !== held) begin
        errors++;
        $display("FAIL bp_result_held: o_result=%h required %h", o_result, held);
      end
    end
    i_ready = 1'b1;
    tick();
    check_bit("bp_valid_after", o_valid, 1'b0);
    check_bit("bp_ready_after", o_ready, 1'b1);
  endtask

  task automatic test_flush();
    int lat;
    exp_t dropped;
    logic seen;
    issue(2'b01, 16'd5000, 16'd13, 3'd2);
    repeat (7) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    dropped = sb.pop_back();
    check_bit("flush_ready", o_ready, 1'b1);
    check_bit("flush_busy", o_busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid !== 1'b0) seen = 1'b1;
      if (o_busy !== 1'b0) seen = 1'b1;
      tick();
    end
    check_bit("flush_no_result", seen, 1'b0);
    issue(2'b00, 16'd3, 16'd5, 3'd4);
    collect(1, lat);
    check_latency("post_flush_mul", lat, 17);
    tick();
  endtask

  task automatic test_gwe_stall();
    int lat;
    issue(2'b00, 16'd321, 16'd123, 3'd3);
    repeat (4) tick();
    gwe = 1'b0;
    repeat (4) begin
      i_flush = 1'b1;  // ignored while gwe is low
      tick();
      check_bit("gwe_busy_hold", o_busy, 1'b1);
      check_bit("gwe_no_valid", o_valid, 1'b0);
    end
    i_flush = 1'b0;
    gwe = 1'b1;
    collect(9, lat);
    check_latency("gwe_mul", lat, 21);
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    issue(2'b01, 16'd777, 16'd5, 3'd6);
    repeat (5) tick();
    gwe = 1'b0;
    rst_n = 1'b0;
    tick();
    dropped = sb.pop_back();
    check_bit("rst_mid_ready", o_ready, 1'b1);
    check_bit("rst_mid_valid", o_valid, 1'b0);
    check_bit("rst_mid_busy", o_busy, 1'b0);
    checks++;
    if (o_result !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: o_result=%h o_tag=%h required 0 0", o_result, o_tag);
    end
    rst_n = 1'b1;
    gwe = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [1:0]  op;
    logic [15:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      issue(op, a, b, TW'($urandom));
      collect(1, lat);
      check_latency("b2b", lat, exp_latency(op, b));
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_divmod();
    test_div_zero();
    test_backpressure();
    test_flush();
    test_gwe_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
